// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared defaults and FSM state type for the register-bank write arbiter
package regbank_pkg;

  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 32;
  localparam int LOCK_MAX_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR0   = 2'd1,
    WR1   = 2'd2,
    LOCK1 = 2'd3
  } arb_state_e;

endpackage

// File: rtl/regbank_addr_decoder.sv
// rtl/regbank_addr_decoder.sv - register address to one-hot write strobe decode
module regbank_addr_decoder
  import regbank_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic                   en_i,
  output logic [(2**ADDR_W)-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < 2**ADDR_W; i++) begin
      onehot_o[i] = en_i && (addr_i == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/regbank_arbiter.sv
// rtl/regbank_arbiter.sv - two-port round-robin register-bank write arbiter with port-1 burst lock
// Optional: REGBANK_ARB_ZERO_PROTECT_EN makes register 0 read-only (grant issued, strobe suppressed).
module regbank_arbiter
  import regbank_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   req0,
  input  logic [ADDR_W-1:0]      addr0,
  input  logic [DATA_W-1:0]      data0,
  input  logic                   req1,
  input  logic [ADDR_W-1:0]      addr1,
  input  logic [DATA_W-1:0]      data1,
  input  logic                   lock1,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic [(2**ADDR_W)-1:0] reg_write_enable,
  output logic [DATA_W-1:0]      reg_data_in,
  output logic                   reg_read_enable,
  output logic                   busy
);

  localparam int NREG  = 2**ADDR_W;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e        state_q, state_d;
  logic              prio_q, prio_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt0_q, gnt1_q, rd_q, busy_q;
  logic [NREG-1:0]   we_q;
  logic [DATA_W-1:0] data_q, data_d;

  logic              locked, win0, win1, strobe_en;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   onehot;

  // A burst is live once a locked gnt1 has gone out (cnt_q != 0) and lock1 is still held.
  always_comb begin
    locked = ((state_q == LOCK1) || ((state_q == WR1) && (cnt_q != '0)))
             && lock1 && (cnt_q < CNT_W'(LOCK_MAX));
    win0 = 1'b0;
    win1 = 1'b0;
    if (locked) begin
      win1 = req1;
    end else if (req0 && req1) begin
      win0 = !prio_q;
      win1 = prio_q;
    end else begin
      win0 = req0;
      win1 = req1;
    end

    sel_addr = win1 ? addr1 : addr0;
    sel_data = win1 ? data1 : data0;
`ifdef REGBANK_ARB_ZERO_PROTECT_EN
    strobe_en = (win0 || win1) && (sel_addr != '0);
`else
    strobe_en = win0 || win1;
`endif
    data_d = strobe_en ? sel_data : data_q;

    prio_d = prio_q;
    if (win0) prio_d = 1'b1;
    if (win1) prio_d = 1'b0;

    state_d = IDLE;
    cnt_d   = '0;
    if (locked) begin
      state_d = LOCK1;
      cnt_d   = cnt_q + CNT_W'(win1);
    end else if (win1) begin
      state_d = WR1;
      cnt_d   = lock1 ? CNT_W'(1) : '0;
    end else if (win0) begin
      state_d = WR0;
    end
  end

  regbank_addr_decoder #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .addr_i   (sel_addr),
    .en_i     (strobe_en),
    .onehot_o (onehot)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      we_q    <= '0;
      data_q  <= '0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= win0;
      gnt1_q  <= win1;
      we_q    <= onehot;
      data_q  <= data_d;
      rd_q    <= !strobe_en;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign gnt0             = gnt0_q;
  assign gnt1             = gnt1_q;
  assign reg_write_enable = we_q;
  assign reg_data_in      = data_q;
  assign reg_read_enable  = rd_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
// tb/tb_regbank_arbiter.sv - directed and randomized checks of regbank_arbiter against a behavioural model
module tb_regbank_arbiter;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int LMX = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req0, req1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          gnt0, gnt1, reg_read_enable, busy;
  logic [31:0]   reg_write_enable;
  logic [DW-1:0] reg_data_in;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: who wins the next tie, how many locked gnt1 in the current burst, last written data.
  bit          m_prio1;
  int          m_burst;
  logic [31:0] m_data;
  logic        e_g0, e_g1, e_rd, e_busy;
  logic [31:0] e_we, e_data;
  bit          zero_protect;

  regbank_arbiter dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .req0             (req0),
    .addr0            (addr0),
    .data0            (data0),
    .req1             (req1),
    .addr1            (addr1),
    .data1            (data1),
    .lock1            (lock1),
    .gnt0             (gnt0),
    .gnt1             (gnt1),
    .reg_write_enable (reg_write_enable),
    .reg_data_in      (reg_data_in),
    .reg_read_enable  (reg_read_enable),
    .busy             (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prio1 = 1'b0;
    m_burst = 0;
    m_data  = '0;
    e_g0 = 0; e_g1 = 0; e_rd = 0; e_busy = 0;
    e_we = '0; e_data = '0;
  endtask

  // One arbitration decision from the current inputs, applied as the next rising edge samples them.
  task automatic model_edge();
    bit in_burst, w0, w1, wr;
    int a;
    in_burst = (m_burst > 0) && lock1 && (m_burst < LMX);
    w0 = 0;
    w1 = 0;
    if (in_burst)          w1 = req1;
    else if (req0 && req1) begin w0 = !m_prio1; w1 = m_prio1; end
    else                   begin w0 = req0; w1 = req1; end

    a  = w1 ? int'(addr1) : int'(addr0);
    wr = (w0 || w1) && !(zero_protect && a == 0);
    if (wr) m_data = w1 ? data1 : data0;
    if (w0) m_prio1 = 1'b1;
    if (w1) m_prio1 = 1'b0;
    if (in_burst)           m_burst = m_burst + (w1 ? 1 : 0);
    else if (w1 && lock1)   m_burst = 1;
    else                    m_burst = 0;

    e_g0   = w0;
    e_g1   = w1;
    e_we   = wr ? (32'h1 << a) : 32'h0;
    e_data = m_data;
    e_rd   = !wr;
    e_busy = w0 || w1 || in_burst;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt0"}, 64'(gnt0), 64'(e_g0));
    chk({tag, ".gnt1"}, 64'(gnt1), 64'(e_g1));
    chk({tag, ".we"},   64'(reg_write_enable), 64'(e_we));
    chk({tag, ".data"}, 64'(reg_data_in), 64'(e_data));
    chk({tag, ".rd"},   64'(reg_read_enable), 64'(e_rd));
    chk({tag, ".busy"}, 64'(busy), 64'(e_busy));
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clock);
    @(negedge clock);
    check_all(tag);
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int n1;
    bit seen0;
`ifdef REGBANK_ARB_ZERO_PROTECT_EN
    zero_protect = 1'b1;
`else
    zero_protect = 1'b0;
`endif
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check_all("reset");
    reset_n = 1'b1;

    // Single port-0 write to register 5.
    req0 = 1; addr0 = 5'd5; data0 = 32'hF305218F;
    cycle("wr5");
    chk("wr5.gnt0_direct", 64'(gnt0), 64'd1);
    chk("wr5.we_direct", 64'(reg_write_enable), 64'h20);
    chk("wr5.data_direct", 64'(reg_data_in), 64'hF305218F);
    idle_inputs();
    cycle("wr5.after");

    // Both ports held from reset alternate, port 0 first.
    do_reset();
    req0 = 1; addr0 = 5'd3; data0 = 32'h1111_0000;
    req1 = 1; addr1 = 5'd9; data1 = 32'h2222_0000;
    for (int i = 0; i < 4; i++) begin
      cycle("rr");
      chk("rr.alt_gnt0", 64'(gnt0), 64'(i % 2 == 0));
      chk("rr.alt_gnt1", 64'(gnt1), 64'(i % 2 == 1));
    end

    // Locked burst: port 1 gets exactly LOCK_MAX grants, then the pending port 0 request.
    idle_inputs();
    req0 = 1; addr0 = 5'd1; data0 = 32'hAAAA_0001;
    cycle("prelock");
    req1 = 1; lock1 = 1; addr1 = 5'd7; data1 = 32'hBBBB_0007;
    n1 = 0;
    seen0 = 0;
    for (int i = 0; i < 20 && !seen0; i++) begin
      cycle("lock");
      if (gnt1) n1++;
      if (gnt0) seen0 = 1;
    end
    chk("lock.count", 64'(n1), 64'(LMX));
    chk("lock.then_gnt0", 64'(seen0), 64'd1);
    idle_inputs();
    cycle("lock.after");

    // Write to register 0.
    req0 = 1; addr0 = 5'd0; data0 = 32'hFFFFFFFF;
    cycle("zero");
    chk("zero.gnt0_direct", 64'(gnt0), 64'd1);
    chk("zero.we_direct", 64'(reg_write_enable), zero_protect ? 64'h0 : 64'h1);
    idle_inputs();
    cycle("zero.after");

    // Reset asserted while a port-1 write is being output.
    req1 = 1; addr1 = 5'd12; data1 = 32'hCAFE_F00D;
    cycle("wr1");
    chk("wr1.gnt1_direct", 64'(gnt1), 64'd1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("midreset");
    req0 = 1; addr0 = 5'd2; data0 = 32'h0000_0202;
    req1 = 1; addr1 = 5'd4; data1 = 32'h0000_0404;
    @(negedge clock);
    reset_n = 1'b1;
    cycle("postreset");
    chk("postreset.tie_gnt0", 64'(gnt0), 64'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req0  = ($urandom_range(0, 99) < 60);
      req1  = ($urandom_range(0, 99) < 60);
      lock1 = ($urandom_range(0, 99) < 75);
      addr0 = AW'($urandom);
      addr1 = AW'($urandom);
      data0 = $urandom;
      data1 = $urandom;
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
